fft_reorder: RTL and testbench
==============================

FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 Parameter NB, 8, bit width of each real/imag component.
REQ-002 Parameter N, 16, FFT points per frame; power of two, N >= 4.
REQ-003 Local constant LOG2N, derived, log2(N); write address width is LOG2N-1.
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_rst  in  1  reset, synchronous and active-high.
REQ-006 i_valid  in  1  input pair qualifier; gaps allowed.
REQ-007 i_data_0r/i_data_0i  in  NB each  lane-0 sample, bit-reversed order.
REQ-008 i_data_1r/i_data_1i  in  NB each  lane-1 sample, bit-reversed order.
REQ-009 o_valid  out  1  output pair qualifier.
REQ-010 o_data_0r/o_data_0i  out  NB each  lane-0 sample X[m], natural order.
REQ-011 o_data_1r/o_data_1i  out  NB each  lane-1 sample X[m+N/2], natural order.

Function
REQ-012 Block SHALL be the output-side reorder buffer of the two-lane delay-switch FFT; it converts bit-reversed two-lane frames to natural order.
REQ-013 Input pair k (0..N/2-1, counting only i_valid cycles) carries X[bitrev(2k)] on lane 0 and X[bitrev(2k)+N/2] on lane 1, bitrev over LOG2N bits.
REQ-014 Write counter k SHALL increment only when i_valid=1 and wrap from N/2-1 to 0, toggling the write page.
REQ-015 Lane 0 SHALL write bank0[wpage][rev(k)], lane 1 SHALL write bank1[wpage][rev(k)], rev over LOG2N-1 bits.
REQ-016 Two pages (ping-pong) SHALL exist; the completed page is read while the other is written.
REQ-017 Read FSM states: IDLE, READ; IDLE->READ in the cycle after the write of k=N/2-1; READ->IDLE after N/2 reads unless another frame completed in that cycle, then stays READ on the toggled page.
REQ-018 In READ, read counter m SHALL run 0..N/2-1 with no gaps, reading bank0[rpage][m] and bank1[rpage][m].
REQ-019 Outputs SHALL be registered; o_valid high exactly N/2 consecutive cycles, first high 2 edges after the edge capturing the last input pair.
REQ-020 Back-to-back frames with i_valid constantly high SHALL give continuous o_valid with no gap or overlap.
REQ-021 Input gaps mid-frame SHALL delay output start by the gap length; output stays contiguous.
REQ-022 No backpressure exists; overrun is impossible by construction and no overrun check SHALL be added.
REQ-023 When o_valid=0, o_data_* SHALL hold their last value.

Reset
REQ-024 With i_rst=1 at a clock edge: k, m, pages=0, FSM=IDLE, o_valid=0, o_data_*=0.
REQ-025 Reset mid-frame SHALL discard the partial input frame and any frame being read; memory contents need no clearing.
REQ-026 First frame after reset SHALL start at k=0 with the first i_valid.

Configuration
REQ-027 Macro FFT_REORDER_LAST_EN defined: output port o_last (1 bit) SHALL exist, high with o_valid for m=N/2-1 only, reset 0.
REQ-028 Macro FFT_REORDER_LAST_EN undefined: o_last port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Bit-reverse function and LOG2 constant function SHALL live in the shared FFT common package/include.
REQ-030 Page storage SHALL be one sub-module fft_reorder_mem (one write port, one read port, parameters NB, depth 2*(N/2)), instantiated once per lane.
REQ-031 Write counter, page toggles and read FSM SHALL stay in fft_reorder.

Verification (N=8, data = natural index in real part, imag = 100+index)
REQ-032 Pairs (0,4),(2,6),(1,5),(3,7) with i_valid high 4 cycles -> o_valid 4 cycles from edge+2: (0,4),(1,5),(2,6),(3,7).
REQ-033 Three back-to-back frames -> o_valid high 12 consecutive cycles, each frame in natural order.
REQ-034 Same frame with i_valid low 3 cycles after pair 1 -> output identical, start delayed 3 cycles, contiguous.
REQ-035 i_rst pulse after pair 2, then full frame -> only one 4-cycle output burst, correct order, no stale data.
REQ-036 With FFT_REORDER_LAST_EN -> o_last high only with pair (3,7); without it -> build with no o_last port.

Source files
------------

// File: rtl/fft_reorder_pkg.sv
// fft_reorder_pkg -- shared FFT helpers for the output reorder buffer.
//   log2c   : ceil(log2(v)), usable in localparam declarations.
//   bit_rev : reverse the low 'bits' bits of v (upper result bits are zero).
//   rd_state_t : read FSM encoding.
//   NUM_LANES  : the delay-switch FFT delivers two samples per cycle.
//   RD_LAT     : edges from a read request to the registered output.
package fft_reorder_pkg;

    typedef enum logic {ST_IDLE, ST_READ} rd_state_t;

    localparam int NUM_LANES = 2;
    localparam int RD_LAT    = 2;

    function automatic int log2c(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] bit_rev(input logic [31:0] v, input int bits);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < bits) r[i] = v[bits-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_mem.sv
// fft_reorder_mem -- page storage for one lane of the reorder buffer.
// Simple dual-port RAM: one write port, one registered read port.
// Address MSB selects the ping-pong page; the rest indexes within a page.
// Ports:
//   i_clk            clock
//   i_we/i_waddr/i_wdata   write port ({re, im} packed)
//   i_re/i_raddr     read request; o_rdata valid the edge after i_re
//   o_rdata          read data, holds when i_re=0
module fft_reorder_mem #(
    parameter int NB    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            i_clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [2*NB-1:0] i_wdata,
    input  logic            i_re,
    input  logic [AW-1:0]   i_raddr,
    output logic [2*NB-1:0] o_rdata
);

    logic [2*NB-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= mem[i_raddr];
    end

endmodule

// File: rtl/fft_reorder.sv
// fft_reorder -- output-side reorder buffer of the two-lane delay-switch FFT.
// Accepts frames of N/2 input pairs in bit-reversed order and emits them as
// N/2 pairs in natural order: lane 0 carries X[m], lane 1 carries X[m+N/2].
// Ping-pong pages let a new frame be written while the previous one is read.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_valid, i_data_{0,1}{r,i}  input pair (gaps allowed)
//   o_valid, o_data_{0,1}{r,i}  registered output pair, data holds when idle
//   o_last                  last pair of a frame (only with FFT_REORDER_LAST_EN)
// Build option: define FFT_REORDER_LAST_EN to add the o_last output.
module fft_reorder
    import fft_reorder_pkg::*;
#(
    parameter int NB = 8,
    parameter int N  = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    input  logic [NB-1:0] i_data_0r,
    input  logic [NB-1:0] i_data_0i,
    input  logic [NB-1:0] i_data_1r,
    input  logic [NB-1:0] i_data_1i,
    output logic          o_valid,
    output logic [NB-1:0] o_data_0r,
    output logic [NB-1:0] o_data_0i,
    output logic [NB-1:0] o_data_1r,
    output logic [NB-1:0] o_data_1i
`ifdef FFT_REORDER_LAST_EN
    ,
    output logic          o_last
`endif
);

    localparam int LOG2N = log2c(N);
    localparam int AW    = LOG2N - 1;   // index within a page
    localparam int MA    = LOG2N;       // page bit + index
    localparam int HALF  = N / 2;

    logic [AW-1:0] wk;          // input pair counter
    logic [AW-1:0] rm;          // read counter
    logic          wpage;
    logic          rpage;
    rd_state_t     state;
    logic          frame_done;
    logic          rd_en;
    logic [AW-1:0] wr_idx;

    logic [RD_LAT-1:0] vld_pipe;

    logic [NUM_LANES-1:0][2*NB-1:0] wdata;
    logic [NUM_LANES-1:0][2*NB-1:0] rdata;

    // Pair k holds X[bitrev(2k)]; its natural index halves to rev(k) over
    // one bit fewer, so the page index is rev(k) on both lanes.
    assign wr_idx     = AW'(bit_rev(32'(wk), AW));
    assign frame_done = i_valid && (wk == AW'(HALF - 1));
    assign rd_en      = (state == ST_READ);

    assign wdata[0] = {i_data_0r, i_data_0i};
    assign wdata[1] = {i_data_1r, i_data_1i};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        fft_reorder_mem #(
            .NB   (NB),
            .DEPTH(2 * HALF),
            .AW   (MA)
        ) u_mem (
            .i_clk  (i_clk),
            .i_we   (i_valid),
            .i_waddr({wpage, wr_idx}),
            .i_wdata(wdata[g]),
            .i_re   (rd_en),
            .i_raddr({rpage, rm}),
            .o_rdata(rdata[g])
        );
    end

    assign o_valid = vld_pipe[RD_LAT-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wk        <= '0;
            wpage     <= 1'b0;
            rm        <= '0;
            rpage     <= 1'b0;
            state     <= ST_IDLE;
            vld_pipe  <= '0;
            o_data_0r <= '0;
            o_data_0i <= '0;
            o_data_1r <= '0;
            o_data_1i <= '0;
        end else begin
            if (i_valid) begin
                wk <= wk + AW'(1);
                if (frame_done) wpage <= ~wpage;
            end

            // A frame completing always wins: it can only coincide with the
            // final read of the previous frame, so the burst continues seamlessly.
            if (frame_done) begin
                state <= ST_READ;
                rm    <= '0;
                rpage <= wpage;
            end else if (state == ST_READ) begin
                rm <= rm + AW'(1);
                if (rm == AW'(HALF - 1)) state <= ST_IDLE;
            end

            vld_pipe <= {vld_pipe[RD_LAT-2:0], rd_en};

            if (vld_pipe[0]) begin
                {o_data_0r, o_data_0i} <= rdata[0];
                {o_data_1r, o_data_1i} <= rdata[1];
            end
        end
    end

`ifdef FFT_REORDER_LAST_EN
    logic [RD_LAT-1:0] last_pipe;

    assign o_last = last_pipe[RD_LAT-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) last_pipe <= '0;
        else       last_pipe <= {last_pipe[RD_LAT-2:0], rd_en && (rm == AW'(HALF - 1))};
    end
`endif

endmodule

// File: tb/tb_fft_reorder.sv
module tb_fft_reorder;

    localparam int NB    = 8;
    localparam int N     = 8;
    localparam int HALF  = N / 2;
    localparam int LOG2N = 3;

    logic          i_clk;
    logic          i_rst;
    logic          i_valid;
    logic [NB-1:0] i_data_0r, i_data_0i, i_data_1r, i_data_1i;
    logic          o_valid;
    logic [NB-1:0] o_data_0r, o_data_0i, o_data_1r, o_data_1i;
`ifdef FFT_REORDER_LAST_EN
    logic          o_last;
`endif

    fft_reorder #(.NB(NB), .N(N)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .i_data_0r(i_data_0r),
        .i_data_0i(i_data_0i),
        .i_data_1r(i_data_1r),
        .i_data_1i(i_data_1i),
        .o_valid  (o_valid),
        .o_data_0r(o_data_0r),
        .o_data_0i(o_data_0i),
        .o_data_1r(o_data_1r),
        .o_data_1i(o_data_1i)
`ifdef FFT_REORDER_LAST_EN
        ,
        .o_last   (o_last)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model: natural-order frame assembled from the pair rule,
    // then a schedule of expected output pairs keyed by edge number.
    typedef struct {
        logic [2*NB-1:0] x0;
        logic [2*NB-1:0] x1;
        int              due;
        bit              last;
    } exp_t;

    exp_t            exp_q[$];
    logic [2*NB-1:0] fr [N];        // frame to send, natural order {re, im}
    logic [2*NB-1:0] asm_x [N];     // model's assembled frame
    logic [2*NB-1:0] hold0, hold1;
    int              mk;
    int              edge_n;
    int              total;
    int              bad;

    function automatic int brev(input int v, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    task automatic model_edge(input logic v, input logic r, input logic [2*NB-1:0] d0, input logic [2*NB-1:0] d1);
        exp_t e;
        int   idx;
        if (r) begin
            mk = 0;
            exp_q.delete();
            hold0 = '0;
            hold1 = '0;
        end else if (v) begin
            idx = brev(2 * mk, LOG2N);
            asm_x[idx]        = d0;
            asm_x[idx + HALF] = d1;
            mk++;
            if (mk == HALF) begin
                mk = 0;
                for (int m = 0; m < HALF; m++) begin
                    e.x0   = asm_x[m];
                    e.x1   = asm_x[m + HALF];
                    e.due  = edge_n + 2 + m;
                    e.last = (m == HALF - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic check_out();
        exp_t            e;
        logic            ev;
        logic [2*NB-1:0] e0, e1;
        logic            el;
        if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
            e = exp_q.pop_front();
            ev = 1'b1; e0 = e.x0; e1 = e.x1; el = e.last;
            hold0 = e0; hold1 = e1;
        end else begin
            ev = 1'b0; e0 = hold0; e1 = hold1; el = 1'b0;
        end
        total++;
        assert (o_valid === ev) else begin
            bad++;
            $error("FAIL o_valid edge=%0d got=%b exp=%b", edge_n, o_valid, ev);
        end
        total++;
        assert ({o_data_0r, o_data_0i} === e0) else begin
            bad++;
            $error("FAIL lane0 edge=%0d got=%h exp=%h", edge_n, {o_data_0r, o_data_0i}, e0);
        end
        total++;
        assert ({o_data_1r, o_data_1i} === e1) else begin
            bad++;
            $error("FAIL lane1 edge=%0d got=%h exp=%h", edge_n, {o_data_1r, o_data_1i}, e1);
        end
`ifdef FFT_REORDER_LAST_EN
        total++;
        assert (o_last === el) else begin
            bad++;
            $error("FAIL o_last edge=%0d got=%b exp=%b", edge_n, o_last, el);
        end
`else
        if (el) begin end
`endif
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic step(input logic v, input logic r, input logic [2*NB-1:0] d0, input logic [2*NB-1:0] d1);
        i_valid = v;
        i_rst   = r;
        {i_data_0r, i_data_0i} = d0;
        {i_data_1r, i_data_1i} = d1;
        @(posedge i_clk);
        edge_n++;
        model_edge(v, r, d0, d1);
        @(negedge i_clk);
        check_out();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom), 16'($urandom));
    endtask

    task automatic send_pair(input int k);
        int idx;
        idx = brev(2 * k, LOG2N);
        step(1'b1, 1'b0, fr[idx], fr[idx + HALF]);
    endtask

    // Sends pairs k0..k1-1, inserting gap_len idle cycles after pair gap_after.
    task automatic send_pairs(input int k0, input int k1, input int gap_after, input int gap_len);
        for (int k = k0; k < k1; k++) begin
            send_pair(k);
            if (k == gap_after) idle(gap_len);
        end
    endtask

    task automatic load_index_frame();
        for (int i = 0; i < N; i++) fr[i] = {8'(i), 8'(100 + i)};
    endtask

    task automatic load_random_frame();
        for (int i = 0; i < N; i++) fr[i] = 16'($urandom);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        edge_n = 0;
        mk     = 0;
        hold0  = '0;
        hold1  = '0;

        // Reset state
        step(1'b0, 1'b1, '0, '0);
        step(1'b1, 1'b1, 16'hffff, 16'hffff);
        idle(3);

        // Index frame, contiguous input
        load_index_frame();
        send_pairs(0, HALF, -1, 0);
        idle(8);

        // Three back-to-back random frames
        for (int f = 0; f < 3; f++) begin
            load_random_frame();
            send_pairs(0, HALF, -1, 0);
        end
        idle(8);

        // Index frame with a 3-cycle gap after pair 1
        load_index_frame();
        send_pairs(0, HALF, 1, 3);
        idle(8);

        // Reset after two pairs, then a full frame
        load_random_frame();
        send_pairs(0, 2, -1, 0);
        step(1'b0, 1'b1, '0, '0);
        load_index_frame();
        send_pairs(0, HALF, -1, 0);
        idle(8);

        // Reset in the middle of an output burst
        load_random_frame();
        send_pairs(0, HALF, -1, 0);
        idle(2);
        step(1'b1, 1'b1, 16'h1234, 16'h5678);
        idle(6);

        // Random frames with random gaps, some back-to-back
        for (int f = 0; f < 12; f++) begin
            load_random_frame();
            send_pairs(0, HALF, int'($urandom_range(0, HALF - 1)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 5)));
        end
        idle(10);

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL drain pending=%0d exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
